zebra_frame_source: RTL and testbench
=====================================

// Module: zebra_frame_source
// PURPOSE
//  Synthetic pixel-stream transmitter that drives the 8-bit grey valid/ready stream consumed by the pattern-recognition blocks.
//  Emits full raster frames (row-major, IMG_WIDTH x IMG_HEIGHT) with a horizontal band of vertical white/black stripes.
//  Used as the camera stand-in for bring-up and as the bench stimulus source upstream of the zebra-crossing detection path.
// PARAMETERS
//  IMG_WIDTH    320     pixels per row
//  IMG_HEIGHT   240     rows per frame
//  W            8       pixel width (bits)
//  WHITE_LEVEL  8'd220  stripe "on" value
//  BLACK_LEVEL  8'd30   stripe "off" and background value
//  GAP_CYCLES   16      idle cycles (y_valid low) between frames in continuous mode
// PORTS
//  clk           in   1                       system clock
//  rst_n         in   1                       asynchronous active-low reset
//  start         in   1                       pulse: begin a frame when IDLE
//  continuous    in   1                       1 = loop frames until stop
//  stop          in   1                       pulse: finish current frame, then IDLE
//  stripe_width  in   8                       stripe width in pixels (0 treated as 1), sampled at frame start
//  band_top      in   $clog2(IMG_HEIGHT)      first striped row, sampled at frame start
//  band_bot      in   $clog2(IMG_HEIGHT)      last striped row (inclusive), sampled at frame start
//  y_valid       out  1                       pixel valid
//  y_ready       in   1                       downstream ready
//  y_data        out  W                       pixel value
//  y_sof         out  1                       qualifies first pixel of frame (x=0,y=0)
//  y_eol         out  1                       qualifies last pixel of each row
//  busy          out  1                       state != IDLE
//  frame_count   out  16                      frames completed, wraps at 2^16
// BEHAVIOUR
//  Reset: y_valid=0, y_data=0, y_sof=0, y_eol=0, busy=0, frame_count=0; FSM=IDLE; x/y counters=0.
//  FSM: IDLE -start-> LOAD (1 cycle: latch stripe_width/band_*, x=y=0, phase=white) -> STREAM.
//   STREAM -last-pixel handshake-> frame_count++, then: stop_pend|!continuous -> IDLE; else -> GAP.
//   GAP counts GAP_CYCLES then -> LOAD. stop while GAP -> IDLE immediately. start ignored unless IDLE.
//  stop during STREAM sets stop_pend; frame always completes (no truncated frames). stop_pend cleared in IDLE.
//  Handshake: transfer when y_valid&&y_ready. While y_valid&&!y_ready, y_data/y_sof/y_eol held stable.
//   y_valid never deasserts inside STREAM; it is registered, first pixel valid 1 cycle after LOAD.
//  Pixel rule: striped row iff band_top<=y<=band_bot; in striped rows pixel=WHITE_LEVEL when phase=white else BLACK_LEVEL;
//   non-striped rows all BLACK_LEVEL. No dividers: stripe counter counts 0..stripe_width-1, toggles phase on wrap,
//   reloads to 0 with phase=white at x=0 of every row. band_top>band_bot -> no striped rows.
//  Counters advance only on handshake; x wraps at IMG_WIDTH-1, y at IMG_HEIGHT-1 (frame end).
//  Back-pressure of any length loses/duplicates no pixel. Mid-frame rst_n: all outputs to reset values asynchronously;
//   next start produces a complete frame from (0,0).
//  frame_count 16-bit, wraps 0xFFFF->0.
// CONFIGURATION
//  ZEBRA_SRC_NOISE_EN defined: 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 at reset) adds signed noise
//   in [-8,+7] (LFSR[3:0]) to every pixel, saturating to [0, 2^W-1]; LFSR steps only on handshake.
//  Undefined: pixels are exactly WHITE_LEVEL/BLACK_LEVEL; no LFSR logic present.
// STRUCTURE
//  Shared package vision_stream_pkg: typedef src_state_e {IDLE, LOAD, STREAM, GAP}; default IMG_WIDTH/IMG_HEIGHT,
//   W, WHITE_LEVEL/BLACK_LEVEL constants reused by detectors.
//  One sub-module: raster_counter (x/y position, eol, frame-end on advance) - reusable by stream consumers.
// TESTING
//  Defaults, stripe_width=16, band 120..179, y_ready=1, single frame -> 76800 pixels, 9600 >= 180, 160 per band row, frame_count=1.
//  Random y_ready (50%) -> pixel sequence identical to ready=1 run; y_data stable while stalled.
//  y_sof only on pixel 0; y_eol on x=319 exactly 240 times per frame.
//  continuous=1, stop mid-frame 2 -> frame 2 completes, then busy=0, frame_count=2, no further y_valid.
//  GAP_CYCLES=16, continuous -> exactly 16 non-valid cycles after GAP entry, then LOAD, then next frame.
//  rst_n low at pixel 1000 -> outputs reset same cycle; start -> fresh frame with y_sof on first pixel.
//  stripe_width=0 -> alternating 220/30 per pixel in band rows; band_top=200, band_bot=100 -> all pixels 30.
//  ZEBRA_SRC_NOISE_EN build: all pixels within +/-8 of nominal, none outside [0,255].

Source files
------------

// File: rtl/vision_stream_pkg.sv
// Shared definitions for the 8-bit grey valid/ready pixel stream: frame geometry,
// stripe levels and the frame-source state encoding reused by sources and detectors.
package vision_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } src_state_e;

  localparam int         DEF_IMG_WIDTH   = 320;
  localparam int         DEF_IMG_HEIGHT  = 240;
  localparam int         DEF_W           = 8;
  localparam logic [7:0] DEF_WHITE_LEVEL = 8'd220;
  localparam logic [7:0] DEF_BLACK_LEVEL = 8'd30;
  localparam int         DEF_GAP_CYCLES  = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major x/y position over a WIDTH x HEIGHT frame; advances one pixel per accepted
// transfer and flags end-of-line and end-of-frame for the pixel currently addressed.
module raster_counter
  import vision_stream_pkg::*;
#(
  parameter int WIDTH  = DEF_IMG_WIDTH,
  parameter int HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     advance,
  output logic [cnt_w(WIDTH)-1:0]  x,
  output logic [cnt_w(HEIGHT)-1:0] y,
  output logic                     eol,
  output logic                     frame_end
);

  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);

  logic last_row;

  assign eol       = (x == XW'(WIDTH - 1));
  assign last_row  = (y == YW'(HEIGHT - 1));
  assign frame_end = advance && eol && last_row;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (eol) begin
        x <= '0;
        y <= last_row ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/zebra_frame_source.sv
// Synthetic raster source: full frames with a band of vertical white/black stripes on a valid/ready stream.
// Build macro ZEBRA_SRC_NOISE_EN adds LFSR noise in [-8,+7] to every pixel, saturating.
module zebra_frame_source
  import vision_stream_pkg::*;
#(
  parameter int             IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int             IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int             W           = DEF_W,
  parameter logic [W-1:0]   WHITE_LEVEL = W'(DEF_WHITE_LEVEL),
  parameter logic [W-1:0]   BLACK_LEVEL = W'(DEF_BLACK_LEVEL),
  parameter int             GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         continuous,
  input  logic                         stop,
  input  logic [7:0]                   stripe_width,
  input  logic [cnt_w(IMG_HEIGHT)-1:0] band_top,
  input  logic [cnt_w(IMG_HEIGHT)-1:0] band_bot,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic [W-1:0]                 y_data,
  output logic                         y_sof,
  output logic                         y_eol,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
  localparam int GW = cnt_w(GAP_CYCLES);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_GAP    = GAP;

  logic [1:0]    state;
  logic          stop_pend;
  logic [7:0]    cfg_sw;
  logic [YW-1:0] cfg_top;
  logic [YW-1:0] cfg_bot;
  logic [7:0]    scnt;
  logic          phase;
  logic [GW-1:0] gap_cnt;

  logic          hs;
  logic          eol;
  logic          frame_end;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          striped;
  logic          stripe_wrap;
  logic [W-1:0]  nominal;
  logic [W-1:0]  pixel;

  assign hs = y_valid && y_ready;

  raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT)
  ) u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == ST_LOAD),
    .advance   (hs),
    .x         (x),
    .y         (y),
    .eol       (eol),
    .frame_end (frame_end)
  );

  // Outputs derive only from registered state, so they hold still across any stall.
  assign striped     = (y >= cfg_top) && (y <= cfg_bot);
  assign stripe_wrap = (cfg_sw == 8'd0) || (scnt == cfg_sw - 8'd1);
  assign nominal     = (striped && phase) ? WHITE_LEVEL : BLACK_LEVEL;

`ifdef ZEBRA_SRC_NOISE_EN
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_step;
  logic signed [W+1:0] noisy;

  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign noisy     = $signed({2'b00, nominal}) + $signed({{(W-2){lfsr[3]}}, lfsr[3:0]});

  // NOTE: always_comb assigns a default first so no path leaves pixel unassigned and infers a latch.
  always_comb begin
    pixel = noisy[W-1:0];
    if (noisy < 0) begin
      pixel = '0;
    end else if (noisy > $signed({2'b00, {W{1'b1}}})) begin
      pixel = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (hs) begin
      lfsr <= lfsr_step;
    end
  end
`else
  assign pixel = nominal;
`endif

  assign y_data = y_valid ? pixel : '0;
  assign y_sof  = y_valid && (x == '0) && (y == '0);
  assign y_eol  = y_valid && eol;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stop_pend   <= 1'b0;
      cfg_sw      <= '0;
      cfg_top     <= '0;
      cfg_bot     <= '0;
      scnt        <= '0;
      phase       <= 1'b1;
      gap_cnt     <= '0;
      y_valid     <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          cfg_sw  <= stripe_width;
          cfg_top <= band_top;
          cfg_bot <= band_bot;
          scnt    <= '0;
          phase   <= 1'b1;
          y_valid <= 1'b1;
          state   <= ST_STREAM;
          if (stop) stop_pend <= 1'b1;
        end
        ST_STREAM: begin
          if (stop) stop_pend <= 1'b1;
          if (hs) begin
            // Stripe phase restarts white at the first pixel of every row.
            if (eol) begin
              scnt  <= '0;
              phase <= 1'b1;
            end else if (stripe_wrap) begin
              scnt  <= '0;
              phase <= ~phase;
            end else begin
              scnt <= scnt + 8'd1;
            end
            if (frame_end) begin
              y_valid     <= 1'b0;
              frame_count <= frame_count + 16'd1;
              if (stop_pend || stop || !continuous) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end
            end
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zebra_frame_source.sv
// Directed bench for zebra_frame_source on a reduced 64x48 raster: table of frame configurations
// checked against an arithmetic pixel model, plus sequences for gap timing, stop and mid-frame reset.
module tb_zebra_frame_source;

  localparam int IMG_W = 64;
  localparam int IMG_H = 48;
  localparam int NPIX  = IMG_W * IMG_H;
`ifdef ZEBRA_SRC_NOISE_EN
  localparam int TOL = 8;
`else
  localparam int TOL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic       stop;
  logic [7:0] stripe_width;
  logic [5:0] band_top;
  logic [5:0] band_bot;
  logic       y_valid;
  logic       y_ready;
  logic [7:0] y_data;
  logic       y_sof;
  logic       y_eol;
  logic       busy;
  logic [15:0] frame_count;

  zebra_frame_source #(
    .IMG_WIDTH  (IMG_W),
    .IMG_HEIGHT (IMG_H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .stop         (stop),
    .stripe_width (stripe_width),
    .band_top     (band_top),
    .band_bot     (band_bot),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .y_data       (y_data),
    .y_sof        (y_sof),
    .y_eol        (y_eol),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sw;
    int top;
    int bot;
    bit rnd;
    int exp_white;
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fc   = 0;

  int pix_cnt, white_cnt, bad_cnt, sof_cnt, sof_bad, eol_cnt, eol_bad, stall_bad, drop_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_pix(input int px, input int py, input int sw, input int top, input int bot);
    int s;
    s = (sw == 0) ? 1 : sw;
    if (py >= top && py <= bot && ((px / s) % 2 == 0)) return 220;
    return 30;
  endfunction

  // Drives one frame through the stream, scoring every accepted pixel against the model.
  task automatic run_frame(input bit do_start, input bit rnd, input int stop_at, input int abort_at);
    bit         held;
    logic [7:0] h_data;
    logic       h_sof, h_eol;
    int         px, py, d;
    pix_cnt = 0; white_cnt = 0; bad_cnt = 0; sof_cnt = 0; sof_bad = 0;
    eol_cnt = 0; eol_bad = 0; stall_bad = 0; drop_cnt = 0;
    held = 1'b0; h_data = '0; h_sof = 1'b0; h_eol = 1'b0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < NPIX * 4 + 200; c++) begin
      @(negedge clk);
      stop = 1'b0;
      if (held && (!y_valid || y_data !== h_data || y_sof !== h_sof || y_eol !== h_eol)) stall_bad++;
      held = 1'b0;
      if (abort_at >= 0 && pix_cnt == abort_at) begin
        y_ready = 1'b0;
        return;
      end
      if (!y_valid) begin
        if (pix_cnt > 0) drop_cnt++;
        continue;
      end
      y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!y_ready) begin
        held = 1'b1; h_data = y_data; h_sof = y_sof; h_eol = y_eol;
        continue;
      end
      px = pix_cnt % IMG_W;
      py = pix_cnt / IMG_W;
      d  = int'(y_data) - exp_pix(px, py, int'(stripe_width), int'(band_top), int'(band_bot));
      if (d < -TOL || d > TOL) bad_cnt++;
      if (y_data > 8'd125) white_cnt++;
      if (y_sof) begin
        sof_cnt++;
        if (pix_cnt != 0) sof_bad++;
      end else if (pix_cnt == 0) begin
        sof_bad++;
      end
      if (y_eol !== (px == IMG_W - 1)) eol_bad++;
      if (y_eol) eol_cnt++;
      pix_cnt++;
      if (pix_cnt == stop_at) stop = 1'b1;
      if (pix_cnt == NPIX) begin
        @(posedge clk);
        #1;
        return;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int exp_white);
    check({tag, "_pixels"},     pix_cnt,   NPIX);
    check({tag, "_white"},      white_cnt, exp_white);
    check({tag, "_model_bad"},  bad_cnt,   0);
    check({tag, "_sof_count"},  sof_cnt,   1);
    check({tag, "_sof_place"},  sof_bad,   0);
    check({tag, "_eol_count"},  eol_cnt,   IMG_H);
    check({tag, "_eol_place"},  eol_bad,   0);
    check({tag, "_stall_hold"}, stall_bad, 0);
    check({tag, "_valid_drop"}, drop_cnt,  0);
  endtask

  initial begin
    int gap, late;
    rst_n = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    stripe_width = 8'd16; band_top = 6'd24; band_bot = 6'd35; y_ready = 1'b1;

    vecs[0] = '{16, 24, 35, 1'b0, 384};
    vecs[1] = '{16, 24, 35, 1'b1, 384};
    vecs[2] = '{0,  0,  0,  1'b0, 32};
    vecs[3] = '{0,  40, 20, 1'b0, 0};
    vecs[4] = '{5,  0,  47, 1'b0, 1632};
    vecs[5] = '{255, 47, 47, 1'b0, 64};
    vecs[6] = '{1,  10, 10, 1'b1, 32};
    vecs[7] = '{64, 5,  6,  1'b0, 128};

    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", int'(y_valid), 0);
    check("rst_data",  int'(y_data), 0);
    check("rst_sof",   int'(y_sof), 0);
    check("rst_eol",   int'(y_eol), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_fc",    int'(frame_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      stripe_width = 8'(vecs[i].sw);
      band_top     = 6'(vecs[i].top);
      band_bot     = 6'(vecs[i].bot);
      run_frame(1'b1, vecs[i].rnd, -1, -1);
      exp_fc++;
      check_frame($sformatf("v%0d", i), vecs[i].exp_white);
      @(negedge clk);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
      check($sformatf("v%0d_fc", i), int'(frame_count), exp_fc);
    end

    // Continuous mode: gap length, then stop mid-frame 2 lets frame 2 finish and halts.
    continuous = 1'b1; stripe_width = 8'd16; band_top = 6'd24; band_bot = 6'd35;
    run_frame(1'b1, 1'b0, -1, -1);
    exp_fc++;
    check_frame("cont_f1", 384);
    y_ready = 1'b0;
    gap = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (y_valid) break;
      gap++;
    end
    check("gap_idle_cycles", gap, 17);
    check("gap_next_sof", int'(y_sof), 1);
    run_frame(1'b0, 1'b1, 1000, -1);
    exp_fc++;
    check_frame("cont_f2", 384);
    @(negedge clk);
    check("stop_busy", int'(busy), 0);
    check("stop_fc", int'(frame_count), exp_fc);
    late = 0;
    repeat (40) begin
      @(negedge clk);
      if (y_valid) late++;
    end
    check("stop_no_more_valid", late, 0);

    // Stop while idling between frames returns to IDLE at once.
    y_ready = 1'b1;
    run_frame(1'b1, 1'b0, -1, -1);
    exp_fc++;
    check_frame("gstop_f", 384);
    repeat (3) @(negedge clk);
    check("gstop_busy_in_gap", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("gstop_busy", int'(busy), 0);
    late = 0;
    repeat (30) begin
      @(negedge clk);
      if (y_valid) late++;
    end
    check("gstop_no_valid", late, 0);
    check("gstop_fc", int'(frame_count), exp_fc);

    // Asynchronous reset at pixel 1000, then a fresh frame from (0,0).
    continuous = 1'b0;
    run_frame(1'b1, 1'b0, -1, 1000);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(y_valid), 0);
    check("mid_rst_data",  int'(y_data), 0);
    check("mid_rst_sof",   int'(y_sof), 0);
    check("mid_rst_eol",   int'(y_eol), 0);
    check("mid_rst_busy",  int'(busy), 0);
    check("mid_rst_fc",    int'(frame_count), 0);
    exp_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stripe_width = 8'd0; band_top = 6'd0; band_bot = 6'd47;
    y_ready = 1'b1;
    run_frame(1'b1, 1'b0, -1, -1);
    exp_fc++;
    check_frame("post_rst", 1536);
    @(negedge clk);
    check("post_rst_fc", int'(frame_count), exp_fc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
